isp_debayer_ctrl: RTL
=====================

Name: isp_debayer_ctrl

Overview:
Frame sequencer placed directly in front of isp_debayer_h. It qualifies sensor timing (vsync/href/raw) and forwards it with 1-cycle latency. After the last active line of each frame it injects FLUSH_LINES synthetic lines, which drain the debayer's line buffer so the bottom image rows are output. It also checks line length and line count and reports frame completion and timing errors to the ISP status logic.

Parameters:
BITS, 8, raw pixel width
WIDTH, 1280, active pixels per line
HEIGHT, 960, active lines per frame
FLUSH_LINES, 3, synthetic lines injected after the last active line (debayer vertical latency)
HBLANK, 16, low-href cycles before each flush line and after the last one (min 2)

Ports:
pclk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  run request; sampled only on in_vsync rising edge
in_vsync  in  1  sensor vsync, active high
in_href  in  1  sensor line valid
in_raw  in  BITS  sensor raw pixel
out_vsync  out  1  vsync to debayer
out_href  out  1  href to debayer
out_raw  out  BITS  raw to debayer
busy  out  1  high in ACTIVE or FLUSH
frame_done  out  1  1-cycle pulse at end of flush
err_len  out  1  1-cycle pulse: line length != WIDTH
err_lines  out  1  1-cycle pulse: line count mismatch or flush aborted
line_cnt  out  clog2(HEIGHT+1)  active lines seen this frame

Behaviour:
- Clock pclk, reset rst_n asynchronous active-low; all outputs and state reset to 0; state = IDLE.
- States: IDLE, WAIT_FRAME, ACTIVE, FLUSH_GAP, FLUSH_LINE, DONE.
- IDLE: outputs held 0. Leave to WAIT_FRAME on in_vsync rising edge with enable=1.
- WAIT_FRAME: out_vsync = in_vsync registered; href/raw forced 0. On in_vsync falling edge -> ACTIVE, line_cnt <= 0.
- ACTIVE: out_href/out_raw/out_vsync = inputs delayed 1 cycle. pix counter increments while in_href=1.
- On each in_href falling edge: if pix count != WIDTH, pulse err_len on the next cycle; line_cnt++ (saturates at HEIGHT). When line_cnt reaches HEIGHT -> FLUSH_GAP.
- Hrefs arriving after HEIGHT lines (during flush or after it) are suppressed (out_href=0) and pulse err_lines once per frame.
- in_vsync rising edge in ACTIVE with line_cnt < HEIGHT: pulse err_lines, no flush. Go to WAIT_FRAME if enable=1, else IDLE.
- FLUSH_GAP: out_href=0 for HBLANK cycles. Then -> FLUSH_LINE if flush lines remain, else -> DONE.
- FLUSH_LINE: out_href=1, out_raw=0 for exactly WIDTH cycles, then -> FLUSH_GAP. Flush line counter decrements.
- out_vsync held 0 throughout FLUSH_GAP/FLUSH_LINE.
- in_vsync rising edge during flush: abort flush, pulse err_lines, no frame_done. out_vsync follows input from the next cycle. Next state from enable as above.
- DONE: frame_done pulse 1 cycle -> WAIT_FRAME if enable=1, else IDLE. An in_vsync rising edge in the same cycle is still honoured.
- enable deasserted mid-frame: the current frame and its flush complete; IDLE is entered at the next frame boundary.
- Counters wrap-free: pix counter saturates at WIDTH+1, which is enough to flag long lines.
- Edge detection uses 1-cycle registered copies of in_vsync and in_href.

Decomposition:
- Shared package isp_pkg holds the state encoding constants and a CLOG2 helper for counter widths.
- One sub-module: isp_line_checker. It contains the pix counter, href edge detect and the err_len pulse, so it can be reused by later ISP stages.

Test Plan:
WIDTH=8, HEIGHT=4, FLUSH_LINES=3, HBLANK=4, enable=1. Frame of 4 lines x 8 px, raw=line*16+pix -> out_raw equals input delayed 1 cycle; then 3 flush lines of 8 cycles, href high, raw=0, each preceded by 4 low cycles; frame_done pulses 4 cycles after the last flush line; err_len=err_lines=0.
Line 2 of 7 px -> err_len pulses exactly once, 1 cycle after its href falls; frame still flushes and frame_done pulses.
Only 3 lines, then in_vsync rises -> err_lines pulses, no flush hrefs, no frame_done, state WAIT_FRAME.
in_vsync rises during the 2nd flush line -> out_href drops to 0 next cycle, err_lines pulses, frame_done stays 0.
rst_n low mid-flush for 1 cycle -> all outputs 0 immediately, state IDLE; the next frame is ignored until in_vsync rises with enable=1.
enable=0 sampled at vsync -> out_href stays 0 for the whole frame, busy=0.

Source files
------------

// File: rtl/isp_pkg.sv
// isp_pkg: shared state encoding and counter-width helper for the ISP front-end blocks.
package isp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_FRAME,
    ST_ACTIVE,
    ST_FLUSH_GAP,
    ST_FLUSH_LINE,
    ST_DONE
  } state_e;

  // Bits needed to hold values 0..v-1, never less than one.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/isp_line_checker.sv
// isp_line_checker: href edge detection, per-line pixel count and a one-cycle
// err_len pulse when a line ends with a length other than WIDTH.
module isp_line_checker
  import isp_pkg::*;
#(
  parameter int WIDTH = 1280,
  localparam int PW = clog2(WIDTH + 2)
) (
  input  logic pclk,
  input  logic rst_n,
  input  logic en,
  input  logic in_href,
  output logic href_rise,
  output logic href_fall,
  output logic err_len
);

  localparam logic [PW-1:0] PIX_LEN = PW'(WIDTH);
  localparam logic [PW-1:0] PIX_MAX = PW'(WIDTH + 1);

  logic          href_q;
  logic [PW-1:0] pix_q, pix_d;
  logic          err_len_q, err_len_d;

  // The counter stops at WIDTH+1, which is all that is needed to flag a long line.
  always_comb begin
    href_rise = in_href & ~href_q;
    href_fall = ~in_href & href_q;
    pix_d     = (!en || href_fall) ? '0 :
                (in_href && pix_q != PIX_MAX) ? pix_q + 1'b1 : pix_q;
    err_len_d = en & href_fall & (pix_q != PIX_LEN);
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      href_q    <= 1'b0;
      pix_q     <= '0;
      err_len_q <= 1'b0;
    end else begin
      href_q    <= in_href;
      pix_q     <= pix_d;
      err_len_q <= err_len_d;
    end
  end

  assign err_len = err_len_q;

endmodule

// File: rtl/isp_debayer_ctrl.sv
// isp_debayer_ctrl: qualifies sensor timing for isp_debayer_h, forwards it with one
// cycle of latency and injects flush lines after each frame to drain the line buffer.
module isp_debayer_ctrl
  import isp_pkg::*;
#(
  parameter int BITS        = 8,
  parameter int WIDTH       = 1280,
  parameter int HEIGHT      = 960,
  parameter int FLUSH_LINES = 3,
  parameter int HBLANK      = 16,
  localparam int LW = clog2(HEIGHT + 1)
) (
  input  logic            pclk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic            in_vsync,
  input  logic            in_href,
  input  logic [BITS-1:0] in_raw,
  output logic            out_vsync,
  output logic            out_href,
  output logic [BITS-1:0] out_raw,
  output logic            busy,
  output logic            frame_done,
  output logic            err_len,
  output logic            err_lines,
  output logic [LW-1:0]   line_cnt
);

  localparam int CW = clog2(WIDTH > HBLANK ? WIDTH : HBLANK);
  localparam int FW = clog2(FLUSH_LINES + 1);
  localparam logic [LW-1:0] LAST_LINE = LW'(HEIGHT - 1);
  localparam logic [CW-1:0] GAP_END   = CW'(HBLANK - 1);
  localparam logic [CW-1:0] LINE_END  = CW'(WIDTH - 1);
  localparam logic [FW-1:0] FLUSH_N   = FW'(FLUSH_LINES);

  state_e          state_q, state_d, restart;
  logic            vs_q, vs_rise, vs_fall;
  logic            href_rise, href_fall;
  logic            abort, extra;
  logic [LW-1:0]   line_cnt_q, line_cnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [FW-1:0]   flush_q, flush_d;
  logic            tail_q, tail_d;
  logic            extra_seen_q, extra_seen_d;
  logic            out_vsync_q, out_vsync_d;
  logic            out_href_q, out_href_d;
  logic [BITS-1:0] out_raw_q, out_raw_d;
  logic            busy_q, busy_d;
  logic            frame_done_q, frame_done_d;
  logic            err_lines_q, err_lines_d;

  isp_line_checker #(.WIDTH(WIDTH)) u_line_checker (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .en        (state_q == ST_ACTIVE),
    .in_href   (in_href),
    .href_rise (href_rise),
    .href_fall (href_fall),
    .err_len   (err_len)
  );

  always_comb begin
    vs_rise      = in_vsync & ~vs_q;
    vs_fall      = ~in_vsync & vs_q;
    restart      = enable ? ST_WAIT_FRAME : ST_IDLE;
    state_d      = state_q;
    line_cnt_d   = line_cnt_q;
    cnt_d        = cnt_q;
    flush_d      = flush_q;
    tail_d       = tail_q & ~vs_rise;
    abort        = 1'b0;
    case (state_q)
      ST_IDLE: state_d = (vs_rise && enable) ? ST_WAIT_FRAME : ST_IDLE;
      ST_WAIT_FRAME: begin
        if (vs_rise && !enable) begin
          state_d = ST_IDLE;
        end else if (vs_fall) begin
          state_d    = ST_ACTIVE;
          line_cnt_d = '0;
        end
      end
      ST_ACTIVE: begin
        if (vs_rise) begin
          abort   = 1'b1;
          state_d = restart;
        end else if (href_fall) begin
          line_cnt_d = line_cnt_q + 1'b1;
          if (line_cnt_q == LAST_LINE) begin
            state_d = ST_FLUSH_GAP;
            cnt_d   = '0;
            flush_d = FLUSH_N;
            tail_d  = 1'b1;
          end
        end
      end
      ST_FLUSH_GAP: begin
        if (vs_rise) begin
          abort   = 1'b1;
          state_d = restart;
        end else if (cnt_q == GAP_END) begin
          cnt_d   = '0;
          state_d = (flush_q != '0) ? ST_FLUSH_LINE : ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_FLUSH_LINE: begin
        if (vs_rise) begin
          abort   = 1'b1;
          state_d = restart;
        end else if (cnt_q == LINE_END) begin
          cnt_d   = '0;
          flush_d = flush_q - 1'b1;
          state_d = ST_FLUSH_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = restart;
      default: state_d = ST_IDLE;
    endcase
    // Hrefs past the last active line are swallowed and reported once per frame.
    extra        = href_rise & tail_q & ~extra_seen_q & (state_q != ST_IDLE);
    extra_seen_d = (extra_seen_q & ~vs_rise) | extra;
    err_lines_d  = abort | extra;
    out_vsync_d  = in_vsync & (state_d inside {ST_WAIT_FRAME, ST_ACTIVE});
    out_href_d   = (state_q == ST_ACTIVE && in_href) || state_d == ST_FLUSH_LINE;
    out_raw_d    = (state_q == ST_ACTIVE) ? in_raw : '0;
    busy_d       = state_d inside {ST_ACTIVE, ST_FLUSH_GAP, ST_FLUSH_LINE};
    frame_done_d = state_d == ST_DONE;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      vs_q         <= 1'b0;
      line_cnt_q   <= '0;
      cnt_q        <= '0;
      flush_q      <= '0;
      tail_q       <= 1'b0;
      extra_seen_q <= 1'b0;
      out_vsync_q  <= 1'b0;
      out_href_q   <= 1'b0;
      out_raw_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_lines_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      vs_q         <= in_vsync;
      line_cnt_q   <= line_cnt_d;
      cnt_q        <= cnt_d;
      flush_q      <= flush_d;
      tail_q       <= tail_d;
      extra_seen_q <= extra_seen_d;
      out_vsync_q  <= out_vsync_d;
      out_href_q   <= out_href_d;
      out_raw_q    <= out_raw_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      err_lines_q  <= err_lines_d;
    end
  end

  assign out_vsync  = out_vsync_q;
  assign out_href   = out_href_q;
  assign out_raw    = out_raw_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign err_lines  = err_lines_q;
  assign line_cnt   = line_cnt_q;

endmodule
